// File: rtl/fusion_sensor_packer.sv
// fusion_sensor_packer: producer side of the fusion core's sensor_input_t
// interface. It pairs each LiDAR sample with the freshest non-stale IMU sample
// and emits one packed beat per pair under valid/ready backpressure.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   enable            block enable; gates both input handshakes
//   imu_valid/ready   IMU sample stream (never backpressured while enabled)
//   imu_data          IMU sample
//   lidar_valid/ready LiDAR sample stream (accepted only in IDLE)
//   lidar_data        LiDAR sample
//   sensor_out        {imu_data, lidar_data, valid}, registered, held until sensor_ready
//   sensor_ready      downstream accept
//   drop_count        LiDAR samples dropped on IMU timeout (saturating)
//   frame_count       beats emitted (wrapping)
//   imu_stale         held IMU sample has reached STALE_LIMIT age
module fusion_sensor_packer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned STALE_LIMIT = 255,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    imu_valid,
  output logic                    imu_ready,
  input  logic [DATA_WIDTH-1:0]   imu_data,
  input  logic                    lidar_valid,
  output logic                    lidar_ready,
  input  logic [DATA_WIDTH-1:0]   lidar_data,
  output logic [2*DATA_WIDTH:0]   sensor_out,
  input  logic                    sensor_ready,
  output logic [15:0]             drop_count,
  output logic [15:0]             frame_count,
  output logic                    imu_stale
);

  localparam int unsigned OUT_WIDTH = 2 * DATA_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STALE_LIMIT);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_IMU = 2'd1;
  localparam logic [1:0] S_EMIT     = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;

  logic [DATA_WIDTH-1:0] imu_reg;
  logic                  imu_have;
  logic [CNT_WIDTH-1:0]  imu_age;

  logic [DATA_WIDTH-1:0] lidar_reg;
  logic [DATA_WIDTH-1:0] lidar_reg_nxt;
  logic [CNT_WIDTH-1:0]  wait_cnt;
  logic [CNT_WIDTH-1:0]  wait_nxt;
  logic [OUT_WIDTH-1:0]  out_reg;
  logic [OUT_WIDTH-1:0]  out_nxt;
  logic                  drop_inc;
  logic                  frame_inc;

  logic                  imu_hs;
  logic                  lidar_hs;
  logic                  imu_usable;

  // Handshake and status decode
  assign imu_ready   = enable;
  assign lidar_ready = enable && (state == S_IDLE);
  assign imu_hs      = enable && imu_valid;
  assign lidar_hs    = lidar_ready && lidar_valid;
  assign imu_stale   = imu_have && (imu_age == LIMIT);
  assign imu_usable  = imu_have && !imu_stale;
  assign sensor_out  = out_reg;

  // Held IMU sample and its age; a new sample may overwrite in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imu_reg  <= '0;
      imu_have <= 1'b0;
      imu_age  <= '0;
    end else if (imu_hs) begin
      imu_reg  <= imu_data;
      imu_have <= 1'b1;
      imu_age  <= '0;
    end else if (imu_have && (imu_age < LIMIT)) begin
      imu_age  <= imu_age + CNT_WIDTH'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, pairing and beat formation
  always_comb begin
    state_nxt     = state;
    out_nxt       = out_reg;
    lidar_reg_nxt = lidar_reg;
    wait_nxt      = wait_cnt;
    drop_inc      = 1'b0;
    frame_inc     = 1'b0;
    case (state)
      S_IDLE: begin
        if (lidar_hs) begin
          lidar_reg_nxt = lidar_data;
          // A same-cycle IMU sample is fresher than the held one
          if (imu_hs) begin
            out_nxt   = {imu_data, lidar_data, 1'b1};
            state_nxt = S_EMIT;
          end else if (imu_usable) begin
            out_nxt   = {imu_reg, lidar_data, 1'b1};
            state_nxt = S_EMIT;
          end else begin
            wait_nxt  = '0;
            state_nxt = S_WAIT_IMU;
          end
        end
      end
      S_WAIT_IMU: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (imu_hs) begin
          out_nxt   = {imu_data, lidar_reg, 1'b1};
          state_nxt = S_EMIT;
        end else if ((wait_cnt + CNT_WIDTH'(1)) == LIMIT) begin
          drop_inc  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          wait_nxt  = wait_cnt + CNT_WIDTH'(1);
        end
      end
      S_EMIT: begin
        // Beat held bit-stable until accepted; enable does not abort it
        if (sensor_ready) begin
          out_nxt   = '0;
          frame_inc = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        out_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and status counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg     <= '0;
      lidar_reg   <= '0;
      wait_cnt    <= '0;
      drop_count  <= '0;
      frame_count <= '0;
    end else begin
      out_reg   <= out_nxt;
      lidar_reg <= lidar_reg_nxt;
      wait_cnt  <= wait_nxt;
      if (drop_inc && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
      if (frame_inc) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fusion_sensor_packer.sv
// Scoreboard bench for fusion_sensor_packer: expected beats are queued when
// LiDAR samples are driven and compared when the DUT hands a beat downstream.
module tb_fusion_sensor_packer;

  localparam int unsigned DW = 16;
  localparam int unsigned SL = 8;
  localparam int unsigned CW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic            imu_valid;
  logic            imu_ready;
  logic [DW-1:0]   imu_data;
  logic            lidar_valid;
  logic            lidar_ready;
  logic [DW-1:0]   lidar_data;
  logic [2*DW:0]   sensor_out;
  logic            sensor_ready;
  logic [15:0]     drop_count;
  logic [15:0]     frame_count;
  logic            imu_stale;

  int              n_checks = 0;
  int              n_pass   = 0;
  logic [2*DW-1:0] exp_q[$];

  fusion_sensor_packer #(
    .DATA_WIDTH (DW),
    .STALE_LIMIT(SL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .imu_valid   (imu_valid),
    .imu_ready   (imu_ready),
    .imu_data    (imu_data),
    .lidar_valid (lidar_valid),
    .lidar_ready (lidar_ready),
    .lidar_data  (lidar_data),
    .sensor_out  (sensor_out),
    .sensor_ready(sensor_ready),
    .drop_count  (drop_count),
    .frame_count (frame_count),
    .imu_stale   (imu_stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the edge
  task automatic step(input logic iv, input logic [DW-1:0] id,
                      input logic lv, input logic [DW-1:0] ld);
    imu_valid   = iv;
    imu_data    = id;
    lidar_valid = lv;
    lidar_data  = ld;
    @(posedge clk);
    #1;
    imu_valid   = 1'b0;
    lidar_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, '0);
  endtask

  // Beat monitor: mid-cycle, a valid beat with ready asserted transfers at the next edge
  always @(negedge clk) begin
    logic [2*DW-1:0] e;
    if (rst_n && sensor_out[0] && sensor_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("beat", 64'(sensor_out[2*DW:1]), 64'(e));
      end
    end
  end

  initial begin
    logic [2*DW:0] held;
    logic          bp_ok;
    int            cycles;

    rst_n        = 1'b0;
    enable       = 1'b0;
    imu_valid    = 1'b0;
    lidar_valid  = 1'b0;
    imu_data     = '0;
    lidar_data   = '0;
    sensor_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",         64'(sensor_out),  64'd0);
    check("rst_drop",        64'(drop_count),  64'd0);
    check("rst_frame",       64'(frame_count), 64'd0);
    check("rst_stale",       64'(imu_stale),   64'd0);
    check("rst_imu_ready",   64'(imu_ready),   64'd0);
    check("rst_lidar_ready", 64'(lidar_ready), 64'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    #1;
    check("en_imu_ready",   64'(imu_ready),   64'd1);
    check("en_lidar_ready", 64'(lidar_ready), 64'd1);

    // Basic pair with a held IMU sample
    step(1'b1, 16'h0010, 1'b0, '0);
    idle(2);
    check("basic_lidar_ready", 64'(lidar_ready), 64'd1);
    exp_q.push_back({16'h0010, 16'h0200});
    step(1'b0, '0, 1'b1, 16'h0200);
    check("basic_out", 64'(sensor_out), 64'({16'h0010, 16'h0200, 1'b1}));
    check("emit_lidar_ready", 64'(lidar_ready), 64'd0);
    idle(1);
    check("basic_valid_low", 64'(sensor_out[0]), 64'd0);
    check("basic_frame", 64'(frame_count), 64'd1);

    // Held IMU sample ages out
    idle(10);
    check("imu_stale", 64'(imu_stale), 64'd1);

    // Timeout: stale IMU, no fresh sample arrives
    step(1'b0, '0, 1'b1, 16'h0123);
    cycles = 0;
    while (drop_count == 16'd0 && cycles < 20) begin
      idle(1);
      cycles++;
    end
    check("timeout_cycles",  64'(cycles),      64'(SL));
    check("timeout_drop",    64'(drop_count),  64'd1);
    check("timeout_frame",   64'(frame_count), 64'd1);
    check("timeout_ready",   64'(lidar_ready), 64'd1);
    check("timeout_nobeat",  64'(sensor_out[0]), 64'd0);

    // LiDAR first, IMU three cycles later
    exp_q.push_back({16'h0055, 16'h0AAA});
    step(1'b0, '0, 1'b1, 16'h0AAA);
    idle(2);
    check("wait_lidar_ready", 64'(lidar_ready), 64'd0);
    step(1'b1, 16'h0055, 1'b0, '0);
    check("lfirst_out", 64'(sensor_out), 64'({16'h0055, 16'h0AAA, 1'b1}));
    idle(1);
    check("lfirst_drop",  64'(drop_count),  64'd1);
    check("lfirst_frame", 64'(frame_count), 64'd2);

    // Backpressure: beat held while a new IMU sample arrives
    sensor_ready = 1'b0;
    exp_q.push_back({16'h0055, 16'h0400});
    step(1'b0, '0, 1'b1, 16'h0400);
    held  = sensor_out;
    bp_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) step(1'b1, 16'h0777, 1'b0, '0);
      else        idle(1);
      if (sensor_out !== held || lidar_ready !== 1'b0) bp_ok = 1'b0;
    end
    check("bp_valid", 64'(held[0]), 64'd1);
    check("bp_hold",  64'(bp_ok),   64'd1);
    sensor_ready = 1'b1;
    idle(1);
    check("bp_frame", 64'(frame_count), 64'd3);
    exp_q.push_back({16'h0777, 16'h0500});
    step(1'b0, '0, 1'b1, 16'h0500);
    idle(1);

    // Same-cycle IMU/LiDAR bypass
    step(1'b1, 16'h0001, 1'b0, '0);
    idle(1);
    exp_q.push_back({16'h0002, 16'h0300});
    step(1'b1, 16'h0002, 1'b1, 16'h0300);
    check("bypass_out", 64'(sensor_out), 64'({16'h0002, 16'h0300, 1'b1}));
    idle(1);
    check("bypass_frame", 64'(frame_count), 64'd5);

    // Asynchronous reset while a beat is in flight
    sensor_ready = 1'b0;
    step(1'b0, '0, 1'b1, 16'h0600);
    check("pre_rst_valid", 64'(sensor_out[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out",   64'(sensor_out),  64'd0);
    check("arst_frame", 64'(frame_count), 64'd0);
    check("arst_drop",  64'(drop_count),  64'd0);
    #2;
    rst_n        = 1'b1;
    sensor_ready = 1'b1;
    exp_q.push_back({16'h0099, 16'h0700});
    step(1'b0, '0, 1'b1, 16'h0700);
    check("post_rst_wait", 64'(sensor_out[0]), 64'd0);
    step(1'b1, 16'h0099, 1'b0, '0);
    check("post_rst_out", 64'(sensor_out), 64'({16'h0099, 16'h0700, 1'b1}));
    idle(2);
    check("post_rst_frame", 64'(frame_count), 64'd1);

    cycles = 0;
    while (exp_q.size() != 0 && cycles < 20) begin
      idle(1);
      cycles++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
